// File: rtl/run_detect_pkg.sv
// Shared types for the run-detector sequencer: FSM state encoding and requester ids.
package run_detect_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    SHIFT = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  function automatic logic [1:0] id_to_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on a tie the requester that was not served last wins.
module rr_arb2
  import run_detect_pkg::*;
(
  input  logic       en,
  input  logic [1:0] req,
  input  logic       last_id,
  output logic [1:0] win,
  output logic       win_id,
  output logic       win_valid
);

  always_comb begin
    win_id    = REQ0;
    win_valid = 1'b0;
    win       = 2'b00;
    if (en && (req != 2'b00)) begin
      win_valid = 1'b1;
      if (req == 2'b11) begin
        win_id = ~last_id;
      end else if (req[1]) begin
        win_id = REQ1;
      end else begin
        win_id = REQ0;
      end
      win = id_to_onehot(win_id);
    end
  end

endmodule

// File: rtl/run_detect_sched.sv
// Shares one serial run detector between two requesters: arbitrate, clear the
// detector, shift the granted word in MSB-first and report how many hits it saw.
module run_detect_sched
  import run_detect_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [WORD_W-1:0] data0,
  input  logic              req1,
  input  logic [WORD_W-1:0] data1,
  output logic [1:0]        grant,
  output logic              busy,
  output logic              det_clr,
  output logic              det_w,
  input  logic              det_z,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  hit_count
);

  state_t            state, state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [CNT_W-1:0]  bit_cnt;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  z_inc;
  logic [1:0]        cur_onehot;
  logic              cur_id;
  logic              last_id;
  logic              arb_en;
  logic [1:0]        win;
  logic              win_id;
  logic              win_valid;
  logic              shift_last;

  assign arb_en     = (state == IDLE) && (req0 || req1);
  assign shift_last = (bit_cnt == CNT_W'(WORD_W - 1));
  assign z_inc      = {{(CNT_W-1){1'b0}}, det_z};

  rr_arb2 u_arb (
    .en        (arb_en),
    .req       ({req1, req0}),
    .last_id   (last_id),
    .win       (win),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (win_valid) state_nxt = CLEAR;
      CLEAR:   state_nxt = SHIFT;
      SHIFT:   if (shift_last) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every output is a decode of registered state so nothing leaks from req or det_z.
  always_comb begin
    busy    = (state != IDLE);
    det_clr = (state == CLEAR);
    grant   = (state == CLEAR) ? cur_onehot : 2'b00;
    det_w   = (state == SHIFT) && shreg[WORD_W-1];
    done    = (state == DONE);
  end

  // Pointer resets to REQ1 as last served, so the first tie goes to req0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      acc        <= '0;
      cur_id     <= REQ0;
      cur_onehot <= 2'b00;
      last_id    <= REQ1;
      done_id    <= 1'b0;
      hit_count  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            shreg      <= win_id ? data1 : data0;
            cur_id     <= win_id;
            cur_onehot <= win;
          end
        end
        CLEAR: begin
          bit_cnt <= '0;
          acc     <= '0;
        end
        SHIFT: begin
          shreg   <= shreg << 1;
          bit_cnt <= bit_cnt + CNT_W'(1);
          acc     <= acc + z_inc;
        end
        DRAIN: begin
          hit_count <= acc + z_inc;
          done_id   <= cur_id;
        end
        DONE: begin
          last_id <= cur_id;
        end
        default: begin
        end
      endcase
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (reset) $onehot0(grant));
  a_done_pulse:   assert property (@(posedge clk) disable iff (reset) done |=> !done);

endmodule

// File: tb/tb_run_detect_sched.sv
// Bench for run_detect_sched: a behavioural run detector on the serial side and a
// scoreboard of expected transactions checked as grants and done pulses appear.
module tb_run_detect_sched;
  import run_detect_pkg::*;

  localparam int WORD_W = 8;
  localparam int CNT_W  = 4;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              req0  = 1'b0;
  logic              req1  = 1'b0;
  logic [WORD_W-1:0] data0 = '0;
  logic [WORD_W-1:0] data1 = '0;
  logic [1:0]        grant;
  logic              busy, det_clr, det_w, det_z, done, done_id;
  logic [CNT_W-1:0]  hit_count;

  typedef struct {
    logic              id;
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  hits;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  logic cur_valid   = 1'b0;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;

  always #5 clk = ~clk;

  run_detect_sched #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .req0      (req0),
    .data0     (data0),
    .req1      (req1),
    .data1     (data1),
    .grant     (grant),
    .busy      (busy),
    .det_clr   (det_clr),
    .det_w     (det_w),
    .det_z     (det_z),
    .done      (done),
    .done_id   (done_id),
    .hit_count (hit_count)
  );

  // Shared detector: Moore, z = the last two bits clocked in were equal.
  logic have_prev = 1'b0;
  logic prev_bit  = 1'b0;
  logic zreg      = 1'b0;
  assign det_z = zreg;

  always @(posedge clk) begin
    if (det_clr) begin
      have_prev <= 1'b0;
      zreg      <= 1'b0;
    end else begin
      zreg      <= have_prev && (det_w == prev_bit);
      prev_bit  <= det_w;
      have_prev <= 1'b1;
    end
  end

  function automatic logic [CNT_W-1:0] exp_hits(input logic [WORD_W-1:0] d);
    int n = 0;
    for (int i = 0; i < WORD_W - 1; i++) if (d[i] == d[i+1]) n++;
    return CNT_W'(n);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_txn(input logic id, input logic [WORD_W-1:0] d);
    exp_t e;
    e.id   = id;
    e.data = d;
    e.hits = exp_hits(d);
    sb.push_back(e);
  endtask

  // Requester behaviour: raise req with data, hold until grant, then drop.
  task automatic apply_stimulus(input logic id, input logic [WORD_W-1:0] d);
    int n = 0;
    if (id) begin data1 = d; req1 = 1'b1; end
    else    begin data0 = d; req0 = 1'b1; end
    do begin
      @(negedge clk);
      n++;
    end while (!grant[id] && n < 100);
    if (!grant[id]) check_output("grant_timeout", 32'd0, 32'd1);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || cur_valid || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) check_output("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #1;
    check_output("rst_grant", grant, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_det_clr", det_clr, 0);
    check_output("rst_det_w", det_w, 0);
    check_output("rst_done", done, 0);
    check_output("rst_done_id", done_id, 0);
    check_output("rst_hit_count", hit_count, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  int   shift_k      = 0;
  int   grant_cyc    = 0;
  int   done_cyc     = 0;
  int   grant_gap    = 0;
  int   idle_len     = 0;
  logic after_done   = 1'b0;
  logic gap_check_en = 1'b0;
  logic prev_busy    = 1'b0;
  logic [1:0] prev_grant = 2'b00;
  logic held_id = 1'b0;
  logic [CNT_W-1:0] held_hits = '0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      cur_valid  = 1'b0;
      shift_k    = 0;
      prev_grant = 2'b00;
      prev_busy  = 1'b0;
      after_done = 1'b0;
      idle_len   = 0;
      held_id    = 1'b0;
      held_hits  = '0;
    end else begin
      if (prev_grant != 2'b00) check_output("grant_pulse", grant, 0);
      prev_grant = grant;
      if (shift_k > 0) begin
        if (shift_k <= WORD_W) check_output("det_w", det_w, cur.data[WORD_W-shift_k]);
        else                   check_output("det_w_drain", det_w, 0);
        shift_k = (shift_k > WORD_W) ? 0 : shift_k + 1;
      end
      if (grant != 2'b00) begin
        if (sb.size() == 0) begin
          check_output("grant_unexpected", grant, 0);
        end else begin
          cur       = sb.pop_front();
          cur_valid = 1'b1;
          check_output("grant", grant, cur.id ? 2'b10 : 2'b01);
          check_output("det_clr", det_clr, 1);
          grant_cyc = cyc;
          grant_gap = cyc - done_cyc;
          shift_k   = 1;
        end
      end
      if (done) begin
        if (!cur_valid) begin
          check_output("done_unexpected", done, 0);
        end else begin
          check_output("done_id", done_id, cur.id);
          check_output("hit_count", hit_count, cur.hits);
          check_output("latency", cyc - grant_cyc, WORD_W + 2);
          cur_valid = 1'b0;
        end
        held_id    = done_id;
        held_hits  = hit_count;
        done_cyc   = cyc;
        after_done = 1'b1;
      end else begin
        check_output("done_id_hold", done_id, held_id);
        check_output("hit_count_hold", hit_count, held_hits);
      end
      if (busy && !prev_busy) begin
        if (gap_check_en && after_done) check_output("idle_gap", idle_len, 1);
        after_done = 1'b0;
      end
      idle_len  = busy ? 0 : idle_len + 1;
      prev_busy = busy;
    end
  end

  initial begin
    #2;
    do_reset();
    @(negedge clk);

    expect_txn(REQ0, 8'b0011_0011);
    apply_stimulus(REQ0, 8'b0011_0011);
    wait_idle();

    expect_txn(REQ1, 8'h00);
    apply_stimulus(REQ1, 8'h00);
    expect_txn(REQ1, 8'hFF);
    apply_stimulus(REQ1, 8'hFF);
    expect_txn(REQ1, 8'hAA);
    apply_stimulus(REQ1, 8'hAA);
    wait_idle();

    // Both held from reset: grants must strictly alternate starting with req0.
    do_reset();
    gap_check_en = 1'b1;
    expect_txn(REQ0, 8'h0F);
    expect_txn(REQ1, 8'h55);
    expect_txn(REQ0, 8'h3C);
    expect_txn(REQ1, 8'hE7);
    fork
      begin
        apply_stimulus(REQ0, 8'h0F);
        apply_stimulus(REQ0, 8'h3C);
      end
      begin
        apply_stimulus(REQ1, 8'h55);
        apply_stimulus(REQ1, 8'hE7);
      end
    join
    wait_idle();
    gap_check_en = 1'b0;

    expect_txn(REQ0, 8'hF0);
    apply_stimulus(REQ0, 8'hF0);
    repeat (4) @(negedge clk);
    check_output("det_w_before_reset", det_w, 1);
    do_reset();
    repeat (20) @(negedge clk);
    check_output("idle_after_reset", busy, 0);
    expect_txn(REQ0, 8'h33);
    apply_stimulus(REQ0, 8'h33);
    wait_idle();

    expect_txn(REQ0, 8'h81);
    expect_txn(REQ1, 8'hCC);
    fork
      apply_stimulus(REQ0, 8'h81);
      begin
        repeat (4) @(negedge clk);
        apply_stimulus(REQ1, 8'hCC);
      end
    join
    wait_idle();
    check_output("rr_wait_gap", grant_gap, 2);

    // A one-cycle req0 pulse during a busy word must be forgotten.
    expect_txn(REQ1, 8'h12);
    fork
      apply_stimulus(REQ1, 8'h12);
      begin
        repeat (3) @(negedge clk);
        data0 = 8'hFF;
        req0  = 1'b1;
        @(negedge clk);
        req0  = 1'b0;
      end
    join
    wait_idle();
    repeat (20) @(negedge clk);
    check_output("stays_idle", busy, 0);
    check_output("scoreboard_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
